// File: rtl/load_buffer.sv
// rtl/load_buffer.sv - load slots: address generation, ROB-gated memory issue, CDB result
// Optional stall counter output enabled by defining LB_STALL_CNT_EN.
module load_buffer #(
    parameter int ROB_SIZE          = 8,
    parameter int LOAD_BUFFER_DEPTH = 3,
    parameter int MEM_LATENCY       = 2,
    localparam int ROB_IX           = $clog2(ROB_SIZE) - 1
) (
`ifdef LB_STALL_CNT_EN
    output logic [15:0]                             stall_count_out,
`endif
    input  logic                                    clk_in,
    input  logic                                    rst_in,
    input  logic                                    valid_in,
    input  logic [ROB_IX:0]                         rob_ix_in,
    input  logic                                    base_ready_in,
    input  logic [31:0]                             base_value_in,
    input  logic [ROB_IX:0]                         base_tag_in,
    input  logic [31:0]                             offset_in,
    output logic                                    ready_out,
    input  logic                                    cdb_valid_in,
    input  logic [ROB_IX:0]                         cdb_rob_ix_in,
    input  logic [31:0]                             cdb_value_in,
    input  logic                                    flush_in,
    output logic [(ROB_IX+1)*LOAD_BUFFER_DEPTH-1:0] lb_rob_arr_ix_out,
    output logic [32*LOAD_BUFFER_DEPTH-1:0]         lb_rob_arr_dest_out,
    input  logic [LOAD_BUFFER_DEPTH-1:0]            can_load_in,
    output logic                                    mem_req_out,
    output logic [31:0]                             mem_addr_out,
    input  logic [31:0]                             mem_data_in,
    output logic                                    result_valid_out,
    output logic [ROB_IX:0]                         result_rob_ix_out,
    output logic [31:0]                             result_value_out,
    input  logic                                    result_grant_in
);

    localparam int N  = LOAD_BUFFER_DEPTH;
    localparam int IW = ROB_IX + 1;
    localparam int CW = $clog2(MEM_LATENCY + 1);

    typedef enum logic [2:0] {
        S_EMPTY,
        S_WAIT_BASE,
        S_ADDR_READY,
        S_MEM_WAIT,
        S_DONE
    } slot_state_t;

    slot_state_t       r_state [N];
    slot_state_t       w_state_nxt [N];
    logic [IW-1:0]     r_rob_ix [N];
    logic [IW-1:0]     r_tag [N];
    logic [31:0]       r_offset [N];
    logic [31:0]       r_addr [N];
    logic [31:0]       r_data [N];
    logic [CW-1:0]     r_cnt;

    logic [N-1:0]      w_empty_mask;
    logic [N-1:0]      w_ready_mask;
    logic [N-1:0]      w_done_mask;
    logic [N-1:0]      w_issue_cand;
    logic [N-1:0]      w_alloc_oh;
    logic [N-1:0]      w_issue_oh;
    logic [N-1:0]      w_res_oh;
    logic              w_mem_busy;
    logic              w_mem_done;
    logic              w_port_free;
    logic              w_alloc;
    logic              w_kill;
    logic              w_cdb_base_hit;

    always_comb begin
        w_empty_mask = '0;
        w_ready_mask = '0;
        w_done_mask  = '0;
        w_mem_busy   = 1'b0;
        for (int i = 0; i < N; i++) begin
            w_empty_mask[i] = (r_state[i] == S_EMPTY);
            w_ready_mask[i] = (r_state[i] == S_ADDR_READY);
            w_done_mask[i]  = (r_state[i] == S_DONE);
            if (r_state[i] == S_MEM_WAIT) w_mem_busy = 1'b1;
        end
    end

    // The completing read frees the port in its final cycle, so back-to-back issue is possible.
    assign w_mem_done     = w_mem_busy && (r_cnt == CW'(1));
    assign w_port_free    = !w_mem_busy || w_mem_done;
    assign w_issue_cand   = w_ready_mask & can_load_in & {N{w_port_free}};
    assign w_alloc_oh     = w_empty_mask & (~w_empty_mask + N'(1));
    assign w_issue_oh     = w_issue_cand & (~w_issue_cand + N'(1));
    assign w_res_oh       = w_done_mask & (~w_done_mask + N'(1));
    assign w_alloc        = valid_in && (|w_empty_mask);
    assign w_kill         = rst_in || flush_in;
    assign w_cdb_base_hit = cdb_valid_in && (cdb_rob_ix_in == base_tag_in);

    always_comb begin
        for (int i = 0; i < N; i++) begin
            w_state_nxt[i] = r_state[i];
            case (r_state[i])
                S_EMPTY:
                    if (w_alloc && w_alloc_oh[i])
                        w_state_nxt[i] = (base_ready_in || w_cdb_base_hit) ? S_ADDR_READY : S_WAIT_BASE;
                S_WAIT_BASE:
                    if (cdb_valid_in && cdb_rob_ix_in == r_tag[i]) w_state_nxt[i] = S_ADDR_READY;
                S_ADDR_READY:
                    if (w_issue_oh[i]) w_state_nxt[i] = S_MEM_WAIT;
                S_MEM_WAIT:
                    if (w_mem_done) w_state_nxt[i] = S_DONE;
                S_DONE:
                    if (w_res_oh[i] && result_grant_in) w_state_nxt[i] = S_EMPTY;
                default:
                    w_state_nxt[i] = S_EMPTY;
            endcase
            if (flush_in) w_state_nxt[i] = S_EMPTY;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < N; i++) begin
                r_state[i]  <= S_EMPTY;
                r_rob_ix[i] <= '0;
                r_tag[i]    <= '0;
                r_offset[i] <= '0;
                r_addr[i]   <= '0;
                r_data[i]   <= '0;
            end
            r_cnt <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                r_state[i] <= w_state_nxt[i];
                if (r_state[i] == S_EMPTY && w_alloc && w_alloc_oh[i]) begin
                    r_rob_ix[i] <= rob_ix_in;
                    r_tag[i]    <= base_tag_in;
                    r_offset[i] <= offset_in;
                    r_addr[i]   <= (base_ready_in ? base_value_in : cdb_value_in) + offset_in;
                end
                if (r_state[i] == S_WAIT_BASE && cdb_valid_in && cdb_rob_ix_in == r_tag[i])
                    r_addr[i] <= cdb_value_in + r_offset[i];
                if (r_state[i] == S_MEM_WAIT && w_mem_done)
                    r_data[i] <= mem_data_in;
            end
            if (flush_in)
                r_cnt <= '0;
            else if (|w_issue_oh)
                r_cnt <= CW'(MEM_LATENCY);
            else if (w_mem_busy)
                r_cnt <= r_cnt - CW'(1);
        end
    end

    always_comb begin
        ready_out           = rst_in || (|w_empty_mask);
        mem_req_out         = !w_kill && (|w_issue_oh);
        mem_addr_out        = '0;
        result_valid_out    = !w_kill && (|w_res_oh);
        result_rob_ix_out   = '0;
        result_value_out    = '0;
        lb_rob_arr_ix_out   = '0;
        lb_rob_arr_dest_out = '0;
        for (int i = 0; i < N; i++) begin
            if (!w_kill && w_issue_oh[i]) mem_addr_out = r_addr[i];
            if (!w_kill && w_res_oh[i]) begin
                result_rob_ix_out = r_rob_ix[i];
                result_value_out  = r_data[i];
            end
            if (!rst_in && (w_ready_mask[i] || w_done_mask[i] || r_state[i] == S_MEM_WAIT)) begin
                lb_rob_arr_ix_out[i*IW +: IW]   = r_rob_ix[i];
                lb_rob_arr_dest_out[i*32 +: 32] = r_addr[i];
            end
        end
    end

`ifdef LB_STALL_CNT_EN
    logic [15:0] r_stall_cnt;
    logic        w_stall;

    assign w_stall = w_port_free && (|w_ready_mask) && !(|(w_ready_mask & can_load_in));

    always_ff @(posedge clk_in) begin
        if (rst_in)
            r_stall_cnt <= '0;
        else if (w_stall && r_stall_cnt != 16'hFFFF)
            r_stall_cnt <= r_stall_cnt + 16'd1;
    end

    assign stall_count_out = r_stall_cnt;
`endif

endmodule

// File: tb/tb_load_buffer.sv
// tb/tb_load_buffer.sv - directed vector bench for load_buffer
module tb_load_buffer;

    localparam int MEM_LATENCY = 2;

    logic        clk = 1'b0;
    logic        rst_in, valid_in, base_ready_in, cdb_valid_in, flush_in, result_grant_in;
    logic [2:0]  rob_ix_in, base_tag_in, cdb_rob_ix_in, can_load_in;
    logic [31:0] base_value_in, offset_in, cdb_value_in, mem_data_in;
    logic        ready_out, mem_req_out, result_valid_out;
    logic [31:0] mem_addr_out, result_value_out;
    logic [2:0]  result_rob_ix_out;
    logic [8:0]  lb_rob_arr_ix_out;
    logic [95:0] lb_rob_arr_dest_out;
`ifdef LB_STALL_CNT_EN
    logic [15:0] stall_count_out;
`endif

    load_buffer #(.ROB_SIZE(8), .LOAD_BUFFER_DEPTH(3), .MEM_LATENCY(MEM_LATENCY)) dut (
`ifdef LB_STALL_CNT_EN
        .stall_count_out(stall_count_out),
`endif
        .clk_in(clk), .rst_in(rst_in), .valid_in(valid_in), .rob_ix_in(rob_ix_in),
        .base_ready_in(base_ready_in), .base_value_in(base_value_in), .base_tag_in(base_tag_in),
        .offset_in(offset_in), .ready_out(ready_out), .cdb_valid_in(cdb_valid_in),
        .cdb_rob_ix_in(cdb_rob_ix_in), .cdb_value_in(cdb_value_in), .flush_in(flush_in),
        .lb_rob_arr_ix_out(lb_rob_arr_ix_out), .lb_rob_arr_dest_out(lb_rob_arr_dest_out),
        .can_load_in(can_load_in), .mem_req_out(mem_req_out), .mem_addr_out(mem_addr_out),
        .mem_data_in(mem_data_in), .result_valid_out(result_valid_out),
        .result_rob_ix_out(result_rob_ix_out), .result_value_out(result_value_out),
        .result_grant_in(result_grant_in)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic rst, valid; logic [2:0] rob; logic br; logic [31:0] bv; logic [2:0] tag;
        logic [31:0] off; logic cv; logic [2:0] ct; logic [31:0] cval; logic fl;
        logic [2:0] cl; logic [31:0] md; logic gr;
    } in_t;
    typedef struct {
        logic ready, req; logic [31:0] addr; logic rv; logic [2:0] rix; logic [31:0] rval;
        logic [8:0] ix; logic [95:0] dest;
    } ex_t;
    typedef struct { in_t i; ex_t e; } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_fail = 0;

    function automatic in_t fi(logic rst, logic valid, logic [2:0] rob, logic br, logic [31:0] bv,
                               logic [2:0] tag, logic [31:0] off, logic cv, logic [2:0] ct,
                               logic [31:0] cval, logic fl, logic [2:0] cl, logic [31:0] md, logic gr);
        in_t x;
        x.rst = rst; x.valid = valid; x.rob = rob; x.br = br; x.bv = bv; x.tag = tag; x.off = off;
        x.cv = cv; x.ct = ct; x.cval = cval; x.fl = fl; x.cl = cl; x.md = md; x.gr = gr;
        return x;
    endfunction

    function automatic ex_t fe(logic ready, logic req, logic [31:0] addr, logic rv, logic [2:0] rix,
                               logic [31:0] rval, logic [8:0] ix, logic [95:0] dest);
        ex_t x;
        x.ready = ready; x.req = req; x.addr = addr; x.rv = rv; x.rix = rix; x.rval = rval;
        x.ix = ix; x.dest = dest;
        return x;
    endfunction

    function automatic in_t idle(logic [2:0] cl);
        return fi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, cl, 0, 0);
    endfunction

    function automatic logic [8:0] ixb(logic [2:0] a, logic [2:0] b, logic [2:0] c);
        return {c, b, a};
    endfunction

    function automatic logic [95:0] dst(logic [31:0] a, logic [31:0] b, logic [31:0] c);
        return {c, b, a};
    endfunction

    function automatic void add(in_t i, ex_t e);
        vec_t v;
        v.i = i; v.e = e;
        vecs.push_back(v);
    endfunction

    task automatic apply(in_t x);
        rst_in = x.rst; valid_in = x.valid; rob_ix_in = x.rob; base_ready_in = x.br;
        base_value_in = x.bv; base_tag_in = x.tag; offset_in = x.off; cdb_valid_in = x.cv;
        cdb_rob_ix_in = x.ct; cdb_value_in = x.cval; flush_in = x.fl; can_load_in = x.cl;
        mem_data_in = x.md; result_grant_in = x.gr;
    endtask

    task automatic chk(string nm, int idx, logic [95:0] act, logic [95:0] exp);
        if (act !== exp) begin
            n_fail++;
            $display("FAIL v%0d %s: got %0h want %0h", idx, nm, act, exp);
        end
    endtask

    ex_t z;
    ex_t e;
    int  got;

    initial begin
        z = fe(1, 0, 0, 0, 0, 0, 0, 0);
        // basic ready-base load
        add(fi(1,0,0,0,0,0,0,0,0,0,0,0,0,0), z);
        add(fi(0,1,2,1,32'h100,0,8,0,0,0,0,3'b001,0,0), z);
        add(idle(3'b001), fe(1,1,32'h108,0,0,0,ixb(2,0,0),dst(32'h108,0,0)));
        add(idle(3'b001), fe(1,0,0,0,0,0,ixb(2,0,0),dst(32'h108,0,0)));
        add(fi(0,0,0,0,0,0,0,0,0,0,0,3'b001,32'hDEAD,0), fe(1,0,0,0,0,0,ixb(2,0,0),dst(32'h108,0,0)));
        add(idle(3'b001), fe(1,0,0,1,2,32'hDEAD,ixb(2,0,0),dst(32'h108,0,0)));
        add(fi(0,0,0,0,0,0,0,0,0,0,0,3'b001,0,1), fe(1,0,0,1,2,32'hDEAD,ixb(2,0,0),dst(32'h108,0,0)));
        add(idle(0), z);
        // base from CDB two cycles after issue, negative offset
        add(fi(0,1,3,0,0,5,32'hFFFF_FFFC,0,0,0,0,3'b111,0,0), z);
        add(idle(3'b111), z);
        add(fi(0,0,0,0,0,0,0,1,5,32'h40,0,3'b111,0,0), z);
        add(idle(3'b111), fe(1,1,32'h3C,0,0,0,ixb(3,0,0),dst(32'h3C,0,0)));
        add(idle(3'b111), fe(1,0,0,0,0,0,ixb(3,0,0),dst(32'h3C,0,0)));
        add(fi(0,0,0,0,0,0,0,0,0,0,0,3'b111,32'h1234,0), fe(1,0,0,0,0,0,ixb(3,0,0),dst(32'h3C,0,0)));
        add(fi(0,0,0,0,0,0,0,0,0,0,0,3'b111,0,1), fe(1,0,0,1,3,32'h1234,ixb(3,0,0),dst(32'h3C,0,0)));
        add(idle(0), z);
        // same-cycle CDB capture, then flush while the read is outstanding
        add(fi(0,1,6,0,0,4,0,1,4,32'h10,0,3'b000,0,0), z);
        add(idle(3'b000), fe(1,0,0,0,0,0,ixb(6,0,0),dst(32'h10,0,0)));
        add(idle(3'b001), fe(1,1,32'h10,0,0,0,ixb(6,0,0),dst(32'h10,0,0)));
        add(fi(0,0,0,0,0,0,0,0,0,0,1,3'b001,0,0), fe(1,0,0,0,0,0,ixb(6,0,0),dst(32'h10,0,0)));
        add(fi(0,0,0,0,0,0,0,0,0,0,0,3'b001,32'hBEEF,0), z);
        add(idle(3'b001), z);
        // fill all slots, out-of-order permission, back-to-back issue
        add(fi(0,1,1,1,32'h1000,0,0,0,0,0,0,3'b000,0,0), z);
        add(fi(0,1,2,1,32'h2000,0,4,0,0,0,0,3'b000,0,0), fe(1,0,0,0,0,0,ixb(1,0,0),dst(32'h1000,0,0)));
        add(fi(0,1,3,1,32'h3000,0,8,0,0,0,0,3'b000,0,0), fe(1,0,0,0,0,0,ixb(1,2,0),dst(32'h1000,32'h2004,0)));
        add(fi(0,1,4,1,32'h4000,0,0,0,0,0,0,3'b010,0,0), fe(0,1,32'h2004,0,0,0,ixb(1,2,3),dst(32'h1000,32'h2004,32'h3008)));
        add(fi(0,1,4,1,32'h4000,0,0,0,0,0,0,3'b010,0,0), fe(0,0,0,0,0,0,ixb(1,2,3),dst(32'h1000,32'h2004,32'h3008)));
        add(fi(0,0,0,0,0,0,0,0,0,0,0,3'b011,32'h22,0), fe(0,1,32'h1000,0,0,0,ixb(1,2,3),dst(32'h1000,32'h2004,32'h3008)));
        add(fi(0,1,4,1,32'h4000,0,0,0,0,0,0,3'b011,0,1), fe(0,0,0,1,2,32'h22,ixb(1,2,3),dst(32'h1000,32'h2004,32'h3008)));
        add(fi(0,0,0,0,0,0,0,0,0,0,0,3'b011,32'h11,0), fe(1,0,0,0,0,0,ixb(1,0,3),dst(32'h1000,0,32'h3008)));
        add(idle(3'b011), fe(1,0,0,1,1,32'h11,ixb(1,0,3),dst(32'h1000,0,32'h3008)));
        add(fi(0,0,0,0,0,0,0,0,0,0,0,3'b011,0,1), fe(1,0,0,1,1,32'h11,ixb(1,0,3),dst(32'h1000,0,32'h3008)));
        // reset mid-operation
        add(fi(1,0,0,0,0,0,0,0,0,0,0,3'b111,0,0), z);
        add(idle(3'b111), z);

        apply(fi(1,0,0,0,0,0,0,0,0,0,0,0,0,0));
        repeat (2) @(posedge clk);

        for (int k = 0; k < vecs.size(); k++) begin
            @(negedge clk);
            apply(vecs[k].i);
            #1;
            n_vec++;
            e = vecs[k].e;
            chk("ready_out", k, 96'(ready_out), 96'(e.ready));
            chk("mem_req_out", k, 96'(mem_req_out), 96'(e.req));
            chk("mem_addr_out", k, 96'(mem_addr_out), 96'(e.addr));
            chk("result_valid_out", k, 96'(result_valid_out), 96'(e.rv));
            chk("result_rob_ix_out", k, 96'(result_rob_ix_out), 96'(e.rix));
            chk("result_value_out", k, 96'(result_value_out), 96'(e.rval));
            chk("ix_bus", k, 96'(lb_rob_arr_ix_out), 96'(e.ix));
            chk("dest_bus", k, lb_rob_arr_dest_out, e.dest);
        end

        // strobe-to-result latency with bounded wait
        @(negedge clk);
        apply(fi(0,1,5,1,32'h500,0,0,0,0,0,0,3'b111,0,0));
        @(negedge clk);
        apply(idle(3'b111));
        #1;
        n_vec++;
        chk("lat_req", 100, 96'(mem_req_out), 96'(1));
        chk("lat_addr", 100, 96'(mem_addr_out), 96'(32'h500));
        got = -1;
        for (int k = 1; k <= 10; k++) begin
            if (got < 0) begin
                @(negedge clk);
                mem_data_in = (k == MEM_LATENCY) ? 32'hCAFE : 32'h0;
                #1;
                if (result_valid_out) got = k;
            end
        end
        n_vec++;
        chk("lat_cycles", 101, 96'(got), 96'(MEM_LATENCY + 1));
        chk("lat_value", 101, 96'(result_value_out), 96'(32'hCAFE));
        chk("lat_rix", 101, 96'(result_rob_ix_out), 96'(5));
        @(negedge clk);
        result_grant_in = 1'b1;
        @(negedge clk);
        result_grant_in = 1'b0;
        #1;
        n_vec++;
        chk("lat_free_ready", 102, 96'(ready_out), 96'(1));
        chk("lat_free_valid", 102, 96'(result_valid_out), 96'(0));

`ifdef LB_STALL_CNT_EN
        @(negedge clk);
        apply(fi(1,0,0,0,0,0,0,0,0,0,0,0,0,0));
        @(negedge clk);
        apply(fi(0,1,7,1,32'h700,0,0,0,0,0,0,3'b000,0,0));
        #1;
        n_vec++;
        chk("stall_reset", 110, 96'(stall_count_out), 96'(0));
        @(negedge clk);
        apply(idle(3'b000));
        repeat (4) @(negedge clk);
        @(negedge clk);
        #1;
        n_vec++;
        chk("stall_count", 111, 96'(stall_count_out), 96'(5));
        chk("stall_no_req", 111, 96'(mem_req_out), 96'(0));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
